// File: rtl/prefetch_arb_pkg.sv
// Shared types and helpers for the prefetch AR arbiter and its routing FIFO.
package prefetch_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 2;

  typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] reqIdx_t;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arbState_t;

  // R data width in bits for a block of (1 << log_bytes) bytes.
  function automatic int data_width(input int log_bytes);
    return 8 << log_bytes;
  endfunction

endpackage

// File: rtl/prefetch_arb_route_fifo.sv
// In-order FIFO of requester indices; one entry per outstanding AR burst.
module prefetch_arb_route_fifo
  import prefetch_arb_pkg::*;
#(
  parameter int  LOG_DEPTH = 3,
  parameter type idx_t     = reqIdx_t
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               push,
  input  logic               pop,
  input  idx_t               din,
  output idx_t               head,
  output logic               empty,
  output logic               full,
  output logic [LOG_DEPTH:0] count
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  idx_t                 mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = count[LOG_DEPTH];

endmodule

// File: rtl/prefetch_ar_arbiter.sv
// Round-robin AR arbiter sharing one AXI read port among NUM_REQ masters, with in-order R routing.
// Optional build macro ARB_PRIO_REQ0_EN: requester 0 wins every arbitration it takes part in.
module prefetch_ar_arbiter
  import prefetch_arb_pkg::*;
#(
  parameter int  NUM_REQ              = 2,
  parameter int  ADDR_BITS            = 64,
  parameter int  TID_WIDTH            = 8,
  parameter int  BURST_LEN_WIDTH      = 8,
  parameter int  LOG_BLOCK_DATA_BYTES = 0,
  parameter int  LOG_OUTSTANDING      = 3,
  localparam int DATA_WIDTH           = data_width(LOG_BLOCK_DATA_BYTES)
) (
  input  logic                                      clk,
  input  logic                                      resetN,
  input  logic [NUM_REQ-1:0]                        s_ar_valid,
  output logic [NUM_REQ-1:0]                        s_ar_ready,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]         s_ar_addr,
  input  logic [NUM_REQ-1:0][BURST_LEN_WIDTH-1:0]   s_ar_len,
  input  logic [NUM_REQ-1:0][TID_WIDTH-1:0]         s_ar_id,
  output logic                                      m_ar_valid,
  input  logic                                      m_ar_ready,
  output logic [ADDR_BITS-1:0]                      m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]                m_ar_len,
  output logic [TID_WIDTH-1:0]                      m_ar_id,
  input  logic                                      m_r_valid,
  output logic                                      m_r_ready,
  input  logic [DATA_WIDTH-1:0]                     m_r_data,
  input  logic                                      m_r_last,
  input  logic [TID_WIDTH-1:0]                      m_r_id,
  output logic [NUM_REQ-1:0]                        s_r_valid,
  input  logic [NUM_REQ-1:0]                        s_r_ready,
  output logic [DATA_WIDTH-1:0]                     s_r_data,
  output logic                                      s_r_last,
  output logic [TID_WIDTH-1:0]                      s_r_id,
  output logic [LOG_OUTSTANDING:0]                  outstandingCnt,
  output logic                                      errUnexpectedR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [0:0] ST_IDLE    = ARB_IDLE;
  localparam logic [0:0] ST_GRANTED = ARB_GRANTED;

  typedef logic [IDX_W-1:0] req_idx_t;

  logic [0:0] state;
  req_idx_t   grant_idx;
  req_idx_t   rr_ptr;
  req_idx_t   next_idx;
  req_idx_t   rr_cand;
  logic       next_found;
  logic       granted;
  logic       ar_hs;
  logic       r_pop;
  req_idx_t   head_idx;
  logic       fifo_empty;
  logic       fifo_full;

  assign granted = (state == ST_GRANTED);

  // Scan from the farthest candidate down so the nearest valid requester after rr_ptr wins.
  always_comb begin
    next_idx   = rr_ptr;
    next_found = 1'b0;
    rr_cand    = rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_cand = req_idx_t'((int'(rr_ptr) + k) % NUM_REQ);
      if (s_ar_valid[rr_cand]) begin
        next_idx   = rr_cand;
        next_found = 1'b1;
      end
    end
`ifdef ARB_PRIO_REQ0_EN
    if (s_ar_valid[0]) begin
      next_idx   = '0;
      next_found = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else if (state == ST_IDLE) begin
      if (next_found && !fifo_full) begin
        state     <= ST_GRANTED;
        grant_idx <= next_idx;
      end
    end else if (ar_hs) begin
      state <= ST_IDLE;
`ifdef ARB_PRIO_REQ0_EN
      if (grant_idx != '0) rr_ptr <= grant_idx;
`else
      rr_ptr <= grant_idx;
`endif
    end
  end

  // AR path: the held grant steers the selected requester straight to memory.
  assign m_ar_valid = granted & s_ar_valid[grant_idx];
  assign m_ar_addr  = s_ar_addr[grant_idx];
  assign m_ar_len   = s_ar_len[grant_idx];
  assign m_ar_id    = s_ar_id[grant_idx];
  assign ar_hs      = m_ar_valid & m_ar_ready;

  always_comb begin
    s_ar_ready = '0;
    if (granted) s_ar_ready[grant_idx] = m_ar_ready;
  end

  prefetch_arb_route_fifo #(
    .LOG_DEPTH (LOG_OUTSTANDING),
    .idx_t     (req_idx_t)
  ) u_route_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (ar_hs),
    .pop    (r_pop),
    .din    (grant_idx),
    .head   (head_idx),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (outstandingCnt)
  );

  // R path: only the requester at the FIFO head sees valid and may apply backpressure.
  assign m_r_ready = !fifo_empty & s_r_ready[head_idx];
  assign r_pop     = m_r_valid & m_r_ready & m_r_last;
  assign s_r_data  = m_r_data;
  assign s_r_last  = m_r_last;
  assign s_r_id    = m_r_id;

  always_comb begin
    s_r_valid = '0;
    if (!fifo_empty) s_r_valid[head_idx] = m_r_valid;
  end

  always_ff @(posedge clk) begin
    if (!resetN)                      errUnexpectedR <= 1'b0;
    else if (m_r_valid && fifo_empty) errUnexpectedR <= 1'b1;
  end

endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// Randomized bench for prefetch_ar_arbiter against a queue-based model of the arbitration and routing rules.
module tb_prefetch_ar_arbiter;

  localparam int NR    = 2;
  localparam int DEPTH = 8;
`ifdef ARB_PRIO_REQ0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 resetN;
  logic [NR-1:0]        s_ar_valid, s_ar_ready;
  logic [NR-1:0][63:0]  s_ar_addr;
  logic [NR-1:0][7:0]   s_ar_len, s_ar_id;
  logic                 m_ar_valid, m_ar_ready;
  logic [63:0]          m_ar_addr;
  logic [7:0]           m_ar_len, m_ar_id;
  logic                 m_r_valid, m_r_ready, m_r_last;
  logic [7:0]           m_r_data, m_r_id;
  logic [NR-1:0]        s_r_valid, s_r_ready;
  logic [7:0]           s_r_data, s_r_id;
  logic                 s_r_last;
  logic [3:0]           outstandingCnt;
  logic                 errUnexpectedR;

  prefetch_ar_arbiter dut (
    .clk(clk), .resetN(resetN),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_r_last(m_r_last), .m_r_id(m_r_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
    .s_r_last(s_r_last), .s_r_id(s_r_id),
    .outstandingCnt(outstandingCnt), .errUnexpectedR(errUnexpectedR)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    int          len;
    logic [63:0] addr;
    logic [7:0]  id;
  } burst_t;

  // Model: issued-but-unfinished bursts in issue order, plus the arbiter's grant/pointer.
  burst_t      route[$];
  bit          mdl_granted;
  int          mdl_g, mdl_rr, beat;
  bit          mdl_err;

  bit          pend[NR];
  logic [63:0] rq_addr[NR];
  int          rq_len[NR];
  logic [7:0]  rq_id[NR];

  int ar_pct, mar_pct, mr_pct, sr_pct, len_max;

  bit            e_mar_valid, e_mr_ready;
  logic [NR-1:0] e_sar_ready, e_sr_valid;

  int grant_log[$];
  int beats_to[NR];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      s_ar_valid[i] = pend[i];
      s_ar_addr[i]  = rq_addr[i];
      s_ar_len[i]   = 8'(rq_len[i]);
      s_ar_id[i]    = rq_id[i];
    end
  endtask

  task automatic gen();
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && $urandom_range(99) < ar_pct) begin
        pend[i]    = 1'b1;
        rq_addr[i] = {$urandom, $urandom};
        rq_len[i]  = $urandom_range(len_max);
        rq_id[i]   = 8'($urandom);
      end
      s_r_ready[i] = ($urandom_range(99) < sr_pct);
    end
    apply();
    m_ar_ready = ($urandom_range(99) < mar_pct);
    if (route.size() > 0 && $urandom_range(99) < mr_pct) begin
      m_r_valid = 1'b1;
      m_r_id    = route[0].id;
      m_r_data  = 8'(route[0].addr) + 8'(beat);
      m_r_last  = (beat == route[0].len);
    end else begin
      m_r_valid = 1'b0;
      m_r_id    = 8'($urandom);
      m_r_data  = 8'($urandom);
      m_r_last  = 1'($urandom);
    end
  endtask

  task automatic compare();
    bit empty;
    int head;
    empty = (route.size() == 0);
    head  = empty ? 0 : route[0].req;
    e_mar_valid = mdl_granted && s_ar_valid[mdl_g];
    e_sar_ready = '0;
    if (mdl_granted && m_ar_ready) e_sar_ready[mdl_g] = 1'b1;
    e_sr_valid = '0;
    if (!empty && m_r_valid) e_sr_valid[head] = 1'b1;
    e_mr_ready = !empty && s_r_ready[head];
    check_eq("m_ar_valid", m_ar_valid, e_mar_valid);
    check_eq("s_ar_ready", s_ar_ready, e_sar_ready);
    check_eq("s_r_valid", s_r_valid, e_sr_valid);
    check_eq("m_r_ready", m_r_ready, e_mr_ready);
    check_eq("outstanding", outstandingCnt, route.size());
    check_eq("err_unexp_r", errUnexpectedR, mdl_err);
    check_eq("s_r_bcast", {s_r_data, s_r_id, s_r_last}, {m_r_data, m_r_id, m_r_last});
    if (e_mar_valid) begin
      check_eq("m_ar_addr", m_ar_addr, rq_addr[mdl_g]);
      check_eq("m_ar_len", m_ar_len, rq_len[mdl_g]);
      check_eq("m_ar_id", m_ar_id, rq_id[mdl_g]);
    end
    for (int i = 0; i < NR; i++) begin
      if (s_ar_valid[i] && s_ar_ready[i]) grant_log.push_back(i);
      if (s_r_valid[i] && s_r_ready[i]) beats_to[i]++;
    end
  endtask

  task automatic update();
    int size0;
    if (!resetN) begin
      route.delete();
      mdl_granted = 1'b0;
      mdl_rr      = 0;
      mdl_err     = 1'b0;
      beat        = 0;
      for (int i = 0; i < NR; i++) pend[i] = 1'b0;
      return;
    end
    size0 = route.size();
    if (m_r_valid && size0 == 0) mdl_err = 1'b1;
    if (m_r_valid && e_mr_ready) begin
      if (m_r_last) begin
        void'(route.pop_front());
        beat = 0;
      end else begin
        beat++;
      end
    end
    if (mdl_granted) begin
      if (e_mar_valid && m_ar_ready) begin
        route.push_back('{mdl_g, rq_len[mdl_g], rq_addr[mdl_g], rq_id[mdl_g]});
        pend[mdl_g] = 1'b0;
        if (!PRIO0 || mdl_g != 0) mdl_rr = mdl_g;
        mdl_granted = 1'b0;
      end
    end else if (size0 < DEPTH && s_ar_valid != '0) begin
      mdl_granted = 1'b1;
      if (PRIO0 && s_ar_valid[0]) begin
        mdl_g = 0;
      end else begin
        for (int k = 1; k <= NR; k++) begin
          if (s_ar_valid[(mdl_rr + k) % NR]) begin
            mdl_g = (mdl_rr + k) % NR;
            break;
          end
        end
      end
    end
  endtask

  task automatic step();
    #1 compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic drain();
    ar_pct = 0; mr_pct = 100; sr_pct = 100; mar_pct = 100;
    for (int c = 0; c < 300; c++) begin
      if (route.size() == 0 && !mdl_granted && !pend[0] && !pend[1]) break;
      gen();
      step();
    end
    check_eq("drain_cnt", outstandingCnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[4];
    resetN = 1'b0;
    ar_pct = 0; mar_pct = 100; mr_pct = 100; sr_pct = 100; len_max = 0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0; rq_addr[i] = '0; rq_len[i] = 0; rq_id[i] = '0; beats_to[i] = 0;
    end
    mdl_granted = 1'b0; mdl_g = 0; mdl_rr = 0; mdl_err = 1'b0; beat = 0;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = '0; m_r_id = '0;
    s_r_ready = '0;
    apply();
    @(negedge clk);

    // Reset held with every requester asking.
    for (int c = 0; c < 2; c++) begin
      gen();
      for (int i = 0; i < NR; i++) pend[i] = 1'b1;
      apply();
      step();
    end
    check_eq("rst_m_ar_valid", m_ar_valid, 0);
    check_eq("rst_s_ar_ready", s_ar_ready, 0);
    check_eq("rst_outstanding", outstandingCnt, 0);
    resetN = 1'b1;

    // Single read from requester 1.
    gen();
    pend[1] = 1'b1; rq_addr[1] = 64'h2A; rq_len[1] = 0; rq_id[1] = 8'h05;
    apply();
    step();
    for (int c = 0; c < 8; c++) begin gen(); step(); end
    check_eq("single_beats_r1", beats_to[1], 1);
    check_eq("single_beats_r0", beats_to[0], 0);
    drain();

    // Continuous contention from both requesters.
    grant_log.delete();
    ar_pct = 100; len_max = 0;
    for (int c = 0; c < 20; c++) begin gen(); step(); end
    exp_order = PRIO0 ? '{0, 0, 0, 0} : '{0, 1, 0, 1};
    check_eq("contention_cnt", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq($sformatf("grant_order_%0d", i), grant_log[i], exp_order[i]);
    drain();

    // Burst routing with a requester-side stall.
    beats_to[0] = 0; beats_to[1] = 0;
    for (int c = 0; c < 20; c++) begin
      gen();
      if (c == 0) begin
        pend[0] = 1'b1; rq_addr[0] = 64'h100; rq_len[0] = 3; rq_id[0] = 8'h11;
      end
      if (c == 2) begin
        pend[1] = 1'b1; rq_addr[1] = 64'h200; rq_len[1] = 0; rq_id[1] = 8'h22;
      end
      apply();
      if (c == 4 || c == 5) s_r_ready[0] = 1'b0;
      step();
    end
    check_eq("burst_beats_r0", beats_to[0], 4);
    check_eq("burst_beats_r1", beats_to[1], 1);
    drain();

    // Fill the routing FIFO with R withheld, then release.
    ar_pct = 100; mr_pct = 0; len_max = 0;
    for (int c = 0; c < 30; c++) begin gen(); step(); end
    check_eq("full_cnt", outstandingCnt, DEPTH);
    check_eq("full_no_ar", m_ar_valid, 0);
    mr_pct = 100;
    for (int c = 0; c < 30; c++) begin gen(); step(); end
    drain();

    // Randomized traffic with knobs reshuffled periodically.
    for (int blk = 0; blk < 15; blk++) begin
      ar_pct  = $urandom_range(100);
      mar_pct = $urandom_range(100, 20);
      mr_pct  = $urandom_range(100);
      sr_pct  = $urandom_range(100, 30);
      len_max = $urandom_range(3);
      for (int c = 0; c < 100; c++) begin gen(); step(); end
    end
    drain();

    // Unexpected R beat with nothing outstanding.
    gen();
    m_r_valid = 1'b1; m_r_last = 1'b1;
    step();
    for (int c = 0; c < 2; c++) begin gen(); step(); end
    check_eq("err_sticky", errUnexpectedR, 1);

    // Reset in the middle of a long burst.
    gen();
    pend[0] = 1'b1; rq_addr[0] = 64'h300; rq_len[0] = 7; rq_id[0] = 8'h33;
    apply();
    step();
    for (int c = 0; c < 40; c++) begin
      if (route.size() > 0 && beat >= 2) break;
      gen();
      step();
    end
    check_eq("midburst_reached", (route.size() > 0 && beat >= 2), 1);
    gen();
    resetN = 1'b0;
    step();
    check_eq("midrst_m_ar_valid", m_ar_valid, 0);
    check_eq("midrst_outstanding", outstandingCnt, 0);
    check_eq("midrst_err", errUnexpectedR, 0);
    check_eq("midrst_m_r_ready", m_r_ready, 0);
    check_eq("midrst_s_r_valid", s_r_valid, 0);
    resetN = 1'b1;
    for (int c = 0; c < 5; c++) begin gen(); step(); end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
